// File: rtl/iob_cache_csrs_mgr.sv
`timescale 1ns / 1ps
// ----------------------------------------------------------------------------
// iob_cache_csrs_mgr
//
// Manager side of the cache CSR control interface (IOb native, word-addressed).
// Converts single-shot host commands into IOb CSR reads/writes, and runs an
// autonomous snapshot that reads the six 32-bit performance counters
// (byte addresses 4..24) into a local register bank. One outstanding IOb
// transaction at a time; every transaction is guarded by a timeout.
//
// Ports
//   clk_i, cke_i, rst_i        clock, clock enable, sync active-high reset
//   cmd_valid_i / cmd_ready_o  command handshake
//   cmd_addr_i                 byte address (bits [1:0] ignored)
//   cmd_wdata_i, cmd_wstrb_i   write data / byte strobes (strobes 0 = read)
//   rsp_valid_o                one-cycle response pulse
//   rsp_rdata_o, rsp_err_o     read data (0 for writes/timeouts), timeout flag
//   snap_i                     start a counter snapshot
//   snap_done_o, snap_err_o    end-of-snapshot pulse, timeout flag
//   snap_data_o                six captured counters, word k = byte addr 4+4k
//   iob_*                      IOb native manager port
// ----------------------------------------------------------------------------
module iob_cache_csrs_mgr #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_W-1:0]     cmd_addr_i,
  input  logic [DATA_W-1:0]     cmd_wdata_i,
  input  logic [DATA_W/8-1:0]   cmd_wstrb_i,
  output logic                  rsp_valid_o,
  output logic [DATA_W-1:0]     rsp_rdata_o,
  output logic                  rsp_err_o,
  input  logic                  snap_i,
  output logic                  snap_done_o,
  output logic                  snap_err_o,
  output logic [6*DATA_W-1:0]   snap_data_o,
  output logic                  iob_valid_o,
  output logic [ADDR_W-3:0]     iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic                  iob_rvalid_i,
  input  logic [DATA_W-1:0]     iob_rdata_i,
  input  logic                  iob_ready_i
);

  localparam int         AW       = ADDR_W - 2;
  localparam int         SW       = DATA_W / 8;
  localparam logic [2:0] LAST_IDX = 3'd5;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t               state_q;
  logic                 snap_mode_q;  // current transaction belongs to a snapshot
  logic [2:0]           idx_q;        // snapshot counter index
  logic [TIMEOUT_W-1:0] tmo_q;
  logic                 ready_q;      // high in IDLE once the command path is free

  logic [TIMEOUT_W-1:0] tmo_inc;
  logic                 tmo_hit;
  logic                 waiting;
  logic                 progress;

  assign tmo_inc  = tmo_q + TIMEOUT_W'(1);
  // Abort on the cycle whose increment would land on the all-ones value, so a
  // stuck transaction waits exactly 2^TIMEOUT_W-1 cycles.
  assign tmo_hit  = &tmo_inc;
  assign waiting  = (state_q == REQ) || (state_q == RESP);
  assign progress = ((state_q == REQ)  && iob_ready_i) ||
                    ((state_q == RESP) && iob_rvalid_i);

  // A pending snapshot request steals the slot, and nothing is accepted while
  // the clock enable is low.
  assign cmd_ready_o = ready_q & ~snap_i & cke_i;

  // Byte-lane bits of the command address have no meaning on a word bus.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^cmd_addr_i[1:0];

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      snap_mode_q <= 1'b0;
      idx_q       <= '0;
      tmo_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      snap_done_o <= 1'b0;
      snap_err_o  <= 1'b0;
      // NOTE: the counter bank is a plain register (not a RAM), so it can and
      // must be cleared by reset along with the control state.
      snap_data_o <= '0;
      iob_valid_o <= 1'b0;
      iob_addr_o  <= '0;
      iob_wdata_o <= '0;
      iob_wstrb_o <= '{default: 1'b0};
    end else if (cke_i) begin
      if (waiting && !progress && tmo_hit) begin
        iob_valid_o <= 1'b0;
        iob_wdata_o <= '0;
        iob_wstrb_o <= '0;
        state_q     <= DONE;
        if (snap_mode_q) begin
          snap_done_o <= 1'b1;
          snap_err_o  <= 1'b1;
        end else begin
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= 1'b1;
          rsp_rdata_o <= '0;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (snap_i) begin
              snap_mode_q <= 1'b1;
              idx_q       <= '0;
              iob_addr_o  <= AW'(1);  // first counter lives at byte address 4
              iob_wdata_o <= '0;
              iob_wstrb_o <= '0;
              iob_valid_o <= 1'b1;
              tmo_q       <= '0;
              ready_q     <= 1'b0;
              state_q     <= REQ;
            end else if (cmd_valid_i && ready_q) begin
              snap_mode_q <= 1'b0;
              iob_addr_o  <= cmd_addr_i[ADDR_W-1:2];
              iob_wdata_o <= cmd_wdata_i;
              iob_wstrb_o <= cmd_wstrb_i;
              iob_valid_o <= 1'b1;
              tmo_q       <= '0;
              ready_q     <= 1'b0;
              state_q     <= REQ;
            end else begin
              ready_q <= 1'b1;
            end
          end

          REQ: begin
            if (iob_ready_i) begin
              iob_valid_o <= 1'b0;
              iob_wdata_o <= '0;
              iob_wstrb_o <= '0;
              tmo_q       <= '0;
              // Writes complete on the request handshake; only commands write.
              if (|iob_wstrb_o) begin
                rsp_valid_o <= 1'b1;
                rsp_rdata_o <= '0;
                rsp_err_o   <= 1'b0;
                state_q     <= DONE;
              end else begin
                state_q <= RESP;
              end
            end else begin
              tmo_q <= tmo_inc;
            end
          end

          RESP: begin
            if (iob_rvalid_i) begin
              if (snap_mode_q) begin
                snap_data_o[int'(idx_q)*DATA_W +: DATA_W] <= iob_rdata_i;
                if (idx_q == LAST_IDX) begin
                  snap_done_o <= 1'b1;
                  snap_err_o  <= 1'b0;
                  state_q     <= DONE;
                end else begin
                  idx_q       <= idx_q + 3'd1;
                  iob_addr_o  <= AW'(idx_q + 3'd2);  // word address of next counter
                  iob_valid_o <= 1'b1;
                  tmo_q       <= '0;
                  state_q     <= REQ;
                end
              end else begin
                rsp_valid_o <= 1'b1;
                rsp_rdata_o <= iob_rdata_i;
                rsp_err_o   <= 1'b0;
                state_q     <= DONE;
              end
            end else begin
              tmo_q <= tmo_inc;
            end
          end

          DONE: begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            snap_done_o <= 1'b0;
            snap_err_o  <= 1'b0;
            snap_mode_q <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Strobe width is tied to the data width; keep the relation explicit.
  localparam int SW_CHECK = SW;

endmodule

// File: doc/iob_cache_csrs_mgr.md
Name: iob_cache_csrs_mgr

Overview:
- Manager (initiator) side of the cache CSR control interface (IOb native, word-addressed).
- Turns single-shot commands from a host or debug controller into IOb CSR reads and writes.
- Also runs an autonomous "snapshot" sequence that reads the six 32-bit performance counters (byte addresses 4..24) into a local register bank.
- Sits between the system controller and the cache CSR subordinate; one outstanding transaction at a time.

Parameters:
- ADDR_W, 5: CSR byte-address width; the IOb address port carries ADDR_W-2 word-address bits.
- DATA_W, 32: CSR data width.
- TIMEOUT_W, 8: timeout counter width; a transaction aborts after 2^TIMEOUT_W-1 cycles without progress.

Ports:
- clk_i  in  1  clock.
- cke_i  in  1  clock enable; when low, all state holds.
- rst_i  in  1  reset, synchronous, active-high.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o.
- cmd_addr_i  in  ADDR_W  byte address.
- cmd_wdata_i  in  DATA_W  write data.
- cmd_wstrb_i  in  DATA_W/8  byte strobes; zero means read.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  DATA_W  read data; 0 for writes.
- rsp_err_o  out  1  timeout flag, qualified by rsp_valid_o.
- snap_i  in  1  start snapshot (pulse or level).
- snap_done_o  out  1  one-cycle pulse at the end of a snapshot.
- snap_err_o  out  1  snapshot aborted by timeout, qualified by snap_done_o.
- snap_data_o  out  6*DATA_W  counters; word k holds byte address 4+4k (RW_HIT in the LSBs through WRITE_MISS).
- iob_valid_o  out  1  IOb request valid.
- iob_addr_o  out  ADDR_W-2  IOb word address.
- iob_wdata_o  out  DATA_W  IOb write data.
- iob_wstrb_o  out  DATA_W/8  IOb write strobes.
- iob_rvalid_i  in  1  IOb read response valid.
- iob_rdata_i  in  DATA_W  IOb read data.
- iob_ready_i  in  1  IOb request accepted.

Behaviour:
- Reset (rst_i=1 at a clock edge, taking priority over cke_i): every output and register goes to 0, including snap_data_o. The FSM returns to IDLE and the timeout counter clears. Reset mid-transaction drops iob_valid_o in the next cycle with no response pulse.
- All outputs are registered. iob_addr_o is cmd_addr_i[ADDR_W-1:2]. iob_wdata_o and iob_wstrb_o are registered at command acceptance and held until the FSM leaves REQ.

FSM states:
- IDLE
  - cmd_ready_o = ~snap_i.
  - If snap_i=1: load snapshot index 0 and go to REQ in snapshot mode. Snapshot has priority over a simultaneous command.
  - Else if cmd_valid_i=1: latch the command and go to REQ.
- REQ
  - iob_valid_o=1.
  - On iob_valid_o & iob_ready_i: for a write (wstrb≠0) go to DONE; for a read go to RESP. iob_valid_o is low in the following cycle (exactly one handshake per request).
- RESP
  - iob_valid_o=0; wait for iob_rvalid_i.
  - On rvalid, capture iob_rdata_i. In command mode go to DONE. In snapshot mode write word[index]; if index=5 go to DONE, otherwise increment the index and return to REQ.
- DONE
  - One cycle.
  - Command mode: rsp_valid_o=1.
  - Snapshot mode: snap_done_o=1.
  - Then go to IDLE.

Latency:
- Command accepted at cycle 0 → iob_valid_o high at cycle 1.
- rsp_valid_o rises the cycle after the DONE transition: one cycle after iob_rvalid_i for reads, or after the ready handshake for writes.

Timeout:
- The counter clears on every entry to REQ or RESP and increments each cycle while in those states.
- At the all-ones value: drop iob_valid_o, set the error flag and go to DONE.
- Command mode gives rsp_err_o=1 with rsp_rdata_o=0.
- Snapshot mode gives snap_err_o=1; words already read keep their new values and unread words keep their old values.

Other rules:
- An iob_rvalid_i outside RESP is ignored.
- iob_ready_i outside REQ is ignored.
- cmd_valid_i outside IDLE is not accepted (cmd_ready_o=0).

Test Plan:
- Read of address 4 with RW_HIT=0x1234_5678 → one IOb handshake with iob_addr_o=1 and wstrb=0; rsp_valid_o pulse carries 0x1234_5678, rsp_err_o=0.
- Write of address 28 with wdata=1 and wstrb=4'b0001 → iob_wstrb_o=4'b0001, iob_addr_o=7; rsp_valid_o one cycle after the ready handshake; no wait for rvalid.
- snap_i with counters preset to 0x11,0x22,...,0x66 → six reads at word addresses 1..6 in order; snap_data_o word k = 0x11*(k+1); a single snap_done_o pulse with snap_err_o=0.
- Responder ready tied low, TIMEOUT_W=4 → iob_valid_o drops after 15 cycles in REQ; rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0; FSM back in IDLE.
- snap_i and cmd_valid_i asserted together → cmd_ready_o=0 and the snapshot runs first; the command is accepted in the first IDLE cycle after snap_done_o.
- rst_i asserted while in RESP → next cycle all outputs 0; a late iob_rvalid_i produces no rsp_valid_o.
